// File: rtl/ape_pingpong_accum_buffer_if.sv
// Signal bundle between the scheduler/adder array, the ping-pong accumulation buffer and the
// output writeback stream. The buffer takes the slave view; the driving side takes the master view.
interface ape_pingpong_accum_buffer_if #(
  parameter int DATA_W    = 16,
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int ROW_IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
);
  logic                                        init;
  logic                                        enable;
  logic [DATA_W-1:0]                           bias;
  logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0]    adder_outputs;
  logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0]    buffer_outputs;
  logic                                        done;
  logic                                        done_ack;
  logic                                        relu_en;
  logic                                        drain_busy;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [WIDTH-1:0][DATA_W-1:0]                out_row;
  logic [ROW_IDX_W-1:0]                        out_row_idx;
  logic                                        out_last;

  modport master (
    output init, enable, bias, adder_outputs, done, relu_en, out_ready,
    input  buffer_outputs, done_ack, drain_busy, out_valid, out_row, out_row_idx, out_last
  );

  modport slave (
    input  init, enable, bias, adder_outputs, done, relu_en, out_ready,
    output buffer_outputs, done_ack, drain_busy, out_valid, out_row, out_row_idx, out_last
  );
endinterface

// File: rtl/ape_pingpong_accum_buffer.sv
// Double-banked APE output accumulation buffer: one bank is preloaded/accumulated while the
// other, handed over on 'done', drains row by row over a valid/ready stream with optional ReLU.
module ape_pingpong_accum_buffer #(
  parameter int DATA_W    = 16,
  parameter int HEIGHT    = 4,
  parameter int WIDTH     = 4,
  parameter int ROW_IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  ape_pingpong_accum_buffer_if.slave  bus
);

  typedef logic [WIDTH-1:0][DATA_W-1:0]             row_t;
  typedef logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0] tile_t;
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(HEIGHT - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic [ROW_IDX_W-1:0] row_r;
  logic [ROW_IDX_W-1:0] row_next_s;
  logic                 act_bank_r;
  logic                 relu_r;
  tile_t                bank0_r;
  tile_t                bank1_r;
  logic                 accept_s;
  logic                 last_s;
  logic                 wr_en_s;
  tile_t                wr_data_s;
  tile_t                act_tile_s;
  tile_t                drain_tile_s;

  function automatic row_t relu_row(input row_t row_in, input logic relu_on);
    row_t row_out;
    for (int j = 0; j < WIDTH; j++) begin
      if (relu_on && row_in[j][DATA_W-1]) begin
        row_out[j] = {DATA_W{1'b0}};
      end else begin
        row_out[j] = row_in[j];
      end
    end
    return row_out;
  endfunction

  // Drain FSM next-state, row counter advance and swap acceptance
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    accept_s     = 1'b0;
    last_s       = (row_r == LAST_ROW);
    case (state_r)
      ST_IDLE: begin
        if (bus.done && !reset) begin
          accept_s     = 1'b1;
          state_next_s = ST_DRAIN;
          row_next_s   = {ROW_IDX_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (last_s) begin
            state_next_s = ST_IDLE;
            row_next_s   = {ROW_IDX_W{1'b0}};
          end else begin
            row_next_s   = row_r + ROW_IDX_W'(1);
          end
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        row_next_s   = {ROW_IDX_W{1'b0}};
      end
    endcase
  end

  // Active-bank write port: init beats enable, and the swap cycle writes nothing
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = bus.adder_outputs;
    if (accept_s) begin
      wr_en_s = 1'b0;
    end else if (bus.init) begin
      wr_en_s   = 1'b1;
      wr_data_s = {(HEIGHT * WIDTH){bus.bias}};
    end else if (bus.enable) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Control state: FSM, row counter, active bank pointer, latched ReLU mode
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      row_r      <= {ROW_IDX_W{1'b0}};
      act_bank_r <= 1'b0;
      relu_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      row_r   <= row_next_s;
      if (accept_s) begin
        act_bank_r <= ~act_bank_r;
        relu_r     <= bus.relu_en;
      end
    end
  end

  // Bank 0 storage; written only while it is the active bank
  always_ff @(posedge clock) begin
    if (reset) begin
      bank0_r <= {(HEIGHT * WIDTH * DATA_W){1'b0}};
    end else if (wr_en_s && (act_bank_r == 1'b0)) begin
      bank0_r <= wr_data_s;
    end
  end

  // Bank 1 storage; written only while it is the active bank
  always_ff @(posedge clock) begin
    if (reset) begin
      bank1_r <= {(HEIGHT * WIDTH * DATA_W){1'b0}};
    end else if (wr_en_s && (act_bank_r == 1'b1)) begin
      bank1_r <= wr_data_s;
    end
  end

  // Route banks to the accumulate side and the drain side
  always_comb begin
    if (act_bank_r) begin
      act_tile_s   = bank1_r;
      drain_tile_s = bank0_r;
    end else begin
      act_tile_s   = bank0_r;
      drain_tile_s = bank1_r;
    end
  end

  // Output drive; the drain row is selected straight from the registered bank
  always_comb begin
    bus.buffer_outputs = act_tile_s;
    bus.done_ack       = accept_s;
    bus.out_valid      = (state_r == ST_DRAIN);
    bus.drain_busy     = (state_r == ST_DRAIN);
    bus.out_row        = relu_row(drain_tile_s[row_r], relu_r);
    bus.out_row_idx    = row_r;
    bus.out_last       = (state_r == ST_DRAIN) && last_s;
  end

endmodule

// File: tb/tb_ape_pingpong_accum_buffer.sv
// Bench for ape_pingpong_accum_buffer: directed scenarios plus a randomized run, all checked
// against a queue-based model of the two banks and the drained-row stream.
module tb_ape_pingpong_accum_buffer;
  localparam int DATA_W    = 16;
  localparam int HEIGHT    = 4;
  localparam int WIDTH     = 4;
  localparam int ROW_IDX_W = 2;

  typedef logic [WIDTH-1:0][DATA_W-1:0]             row_t;
  typedef logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0] tile_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [DATA_W-1:0] m_bank [2][HEIGHT][WIDTH];
  int                m_act;
  row_t              m_q [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ape_pingpong_accum_buffer_if #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .WIDTH(WIDTH),
                                 .ROW_IDX_W(ROW_IDX_W)) bus ();

  ape_pingpong_accum_buffer #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .WIDTH(WIDTH),
                              .ROW_IDX_W(ROW_IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic tile_t fill_tile(input logic [DATA_W-1:0] v);
    tile_t t;
    for (int i = 0; i < HEIGHT; i++)
      for (int j = 0; j < WIDTH; j++)
        t[i][j] = v;
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < HEIGHT; i++)
      for (int j = 0; j < WIDTH; j++)
        t[i][j] = DATA_W'($urandom);
    return t;
  endfunction

  function automatic tile_t model_active();
    tile_t t;
    for (int i = 0; i < HEIGHT; i++)
      for (int j = 0; j < WIDTH; j++)
        t[i][j] = m_bank[m_act][i][j];
    return t;
  endfunction

  // Model: active bank takes writes; an accepted done queues the whole bank as output rows.
  task automatic model_update();
    bit                accept;
    row_t              r;
    logic [DATA_W-1:0] e;
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < HEIGHT; i++)
          for (int j = 0; j < WIDTH; j++)
            m_bank[b][i][j] = '0;
      m_act = 0;
      m_q.delete();
    end else begin
      accept = bus.done && (m_q.size() == 0);
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      if (accept) begin
        for (int i = 0; i < HEIGHT; i++) begin
          for (int j = 0; j < WIDTH; j++) begin
            e = m_bank[m_act][i][j];
            r[j] = (bus.relu_en && $signed(e) < 0) ? '0 : e;
          end
          m_q.push_back(r);
        end
        m_act = 1 - m_act;
      end else if (bus.init) begin
        for (int i = 0; i < HEIGHT; i++)
          for (int j = 0; j < WIDTH; j++)
            m_bank[m_act][i][j] = bus.bias;
      end else if (bus.enable) begin
        for (int i = 0; i < HEIGHT; i++)
          for (int j = 0; j < WIDTH; j++)
            m_bank[m_act][i][j] = bus.adder_outputs[i][j];
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.init          = 1'b0;
    bus.enable        = 1'b0;
    bus.bias          = '0;
    bus.adder_outputs = '0;
    bus.done          = 1'b0;
    bus.relu_en       = 1'b0;
    bus.out_ready     = 1'b1;
  endtask

  task automatic test_reset();
    tile_t zero_t;
    zero_t = '0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks += 6;
    if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    if (bus.drain_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.drain_busy); end
    if (bus.done_ack !== 1'b0)   begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.done_ack); end
    if (bus.out_row_idx !== 2'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", bus.out_row_idx); end
    if (bus.out_last !== 1'b0)   begin failures++; $display("FAIL rst_last got=%b exp=0", bus.out_last); end
    if (bus.buffer_outputs !== zero_t) begin failures++; $display("FAIL rst_buf got=%h exp=0", bus.buffer_outputs); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_init();
    idle_inputs();
    bus.init = 1'b1;
    bus.bias = 16'h0005;
    tick();
    bus.init = 1'b0;
    #1;
    checks += 2;
    if (bus.buffer_outputs !== fill_tile(16'h0005)) begin
      failures++; $display("FAIL init_buf got=%h exp=%h", bus.buffer_outputs, fill_tile(16'h0005));
    end
    if (bus.drain_busy !== 1'b0) begin failures++; $display("FAIL init_busy got=%b exp=0", bus.drain_busy); end
    tick();
  endtask

  task automatic test_drain();
    idle_inputs();
    bus.init = 1'b1;
    bus.bias = 16'h0005;
    tick();
    bus.init          = 1'b0;
    bus.enable        = 1'b1;
    bus.adder_outputs = fill_tile(16'h0010);
    tick();
    bus.enable = 1'b0;
    bus.done   = 1'b1;
    #1;
    checks += 1;
    if (bus.done_ack !== 1'b1) begin failures++; $display("FAIL drain_ack got=%b exp=1", bus.done_ack); end
    tick();
    bus.done = 1'b0;
    #1;
    checks += 1;
    if (bus.done_ack !== 1'b0) begin failures++; $display("FAIL drain_ack_pulse got=%b exp=0", bus.done_ack); end
    for (int r = 0; r < HEIGHT; r++) begin
      checks += 4;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid row=%0d got=%b exp=1", r, bus.out_valid); end
      if (bus.out_row_idx !== ROW_IDX_W'(r)) begin failures++; $display("FAIL drain_idx got=%0d exp=%0d", bus.out_row_idx, r); end
      if (bus.out_last !== (r == HEIGHT - 1)) begin failures++; $display("FAIL drain_last row=%0d got=%b", r, bus.out_last); end
      if (bus.out_row !== fill_tile(16'h0010)[0]) begin
        failures++; $display("FAIL drain_row row=%0d got=%h exp=%h", r, bus.out_row, fill_tile(16'h0010)[0]);
      end
      tick();
      #1;
    end
    checks += 2;
    if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL drain_end_valid got=%b exp=0", bus.out_valid); end
    if (bus.drain_busy !== 1'b0) begin failures++; $display("FAIL drain_end_busy got=%b exp=0", bus.drain_busy); end
  endtask

  task automatic test_relu();
    tile_t       a;
    logic [15:0] exp_v;
    for (int p = 0; p < 2; p++) begin
      idle_inputs();
      a       = fill_tile(16'h0010);
      a[2][1] = 16'hFFF0;
      exp_v   = (p == 0) ? 16'h0000 : 16'hFFF0;
      bus.init = 1'b1;
      tick();
      bus.init          = 1'b0;
      bus.enable        = 1'b1;
      bus.adder_outputs = a;
      tick();
      bus.enable  = 1'b0;
      bus.done    = 1'b1;
      bus.relu_en = (p == 0);
      tick();
      bus.done    = 1'b0;
      bus.relu_en = (p != 0);
      #1;
      for (int r = 0; r < HEIGHT; r++) begin
        if (r == 2) begin
          checks += 2;
          if (bus.out_row[1] !== exp_v) begin
            failures++; $display("FAIL relu_neg pass=%0d got=%h exp=%h", p, bus.out_row[1], exp_v);
          end
          if (bus.out_row[0] !== 16'h0010 || bus.out_row[3] !== 16'h0010) begin
            failures++; $display("FAIL relu_pos pass=%0d got=%h exp=0010", p, bus.out_row);
          end
        end
        tick();
        #1;
      end
    end
  endtask

  task automatic test_backpressure();
    tile_t a;
    tile_t b;
    idle_inputs();
    a = rand_tile();
    b = rand_tile();
    bus.init = 1'b1;
    bus.bias = 16'h0001;
    tick();
    bus.init          = 1'b0;
    bus.enable        = 1'b1;
    bus.adder_outputs = a;
    tick();
    bus.enable = 1'b0;
    bus.done   = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    bus.out_ready     = 1'b0;
    bus.done          = 1'b1;
    bus.adder_outputs = b;
    for (int k = 0; k < 3; k++) begin
      bus.enable = (k == 0);
      #1;
      checks += 3;
      if (bus.out_row_idx !== 2'd1 || bus.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold_idx k=%0d got=%0d exp=1", k, bus.out_row_idx);
      end
      if (bus.out_row !== a[1]) begin failures++; $display("FAIL bp_hold_row k=%0d got=%h exp=%h", k, bus.out_row, a[1]); end
      if (bus.done_ack !== 1'b0) begin failures++; $display("FAIL bp_early_ack k=%0d got=%b exp=0", k, bus.done_ack); end
      tick();
      checks += 1;
      if (bus.buffer_outputs !== b) begin failures++; $display("FAIL bp_active_wr got=%h exp=%h", bus.buffer_outputs, b); end
    end
    bus.enable    = 1'b0;
    bus.out_ready = 1'b1;
    for (int r = 1; r < HEIGHT; r++) begin
      #1;
      checks += 2;
      if (bus.out_row !== a[r] || bus.out_row_idx !== ROW_IDX_W'(r)) begin
        failures++; $display("FAIL bp_row r=%0d got=%h exp=%h", r, bus.out_row, a[r]);
      end
      if (bus.done_ack !== 1'b0) begin failures++; $display("FAIL bp_ack_in_drain r=%0d got=%b exp=0", r, bus.done_ack); end
      tick();
    end
    #1;
    checks += 2;
    if (bus.done_ack !== 1'b1) begin failures++; $display("FAIL bp_ack_after got=%b exp=1", bus.done_ack); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_valid got=%b exp=0", bus.out_valid); end
    tick();
    bus.done = 1'b0;
    for (int r = 0; r < HEIGHT; r++) begin
      #1;
      checks += 1;
      if (bus.out_row !== b[r]) begin failures++; $display("FAIL bp_second_row r=%0d got=%h exp=%h", r, bus.out_row, b[r]); end
      tick();
    end
  endtask

  task automatic test_init_priority();
    idle_inputs();
    bus.init          = 1'b1;
    bus.enable        = 1'b1;
    bus.bias          = 16'h0007;
    bus.adder_outputs = fill_tile(16'h0009);
    tick();
    idle_inputs();
    #1;
    checks += 1;
    if (bus.buffer_outputs !== fill_tile(16'h0007)) begin
      failures++; $display("FAIL prio_buf got=%h exp=%h", bus.buffer_outputs, fill_tile(16'h0007));
    end
    bus.done          = 1'b1;
    bus.init          = 1'b1;
    bus.bias          = 16'h0003;
    bus.enable        = 1'b1;
    bus.adder_outputs = fill_tile(16'h000B);
    #1;
    checks += 1;
    if (bus.done_ack !== 1'b1) begin failures++; $display("FAIL prio_ack got=%b exp=1", bus.done_ack); end
    tick();
    idle_inputs();
    #1;
    checks += 1;
    if (bus.buffer_outputs !== model_active()) begin
      failures++; $display("FAIL accept_nowrite got=%h exp=%h", bus.buffer_outputs, model_active());
    end
    for (int r = 0; r < HEIGHT; r++) begin
      checks += 1;
      if (bus.out_row !== fill_tile(16'h0007)[0]) begin
        failures++; $display("FAIL prio_row r=%0d got=%h exp=%h", r, bus.out_row, fill_tile(16'h0007)[0]);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    tile_t c;
    tile_t zero_t;
    zero_t = '0;
    idle_inputs();
    c = rand_tile();
    bus.enable        = 1'b1;
    bus.adder_outputs = c;
    tick();
    bus.enable = 1'b0;
    bus.done   = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    checks += 1;
    if (bus.out_row_idx !== 2'd2 || bus.out_row !== c[2]) begin
      failures++; $display("FAIL mid_row2 got=%0d/%h exp=2/%h", bus.out_row_idx, bus.out_row, c[2]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
    if (bus.drain_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", bus.drain_busy); end
    if (bus.buffer_outputs !== zero_t) begin failures++; $display("FAIL mid_rst_buf got=%h exp=0", bus.buffer_outputs); end
    tick();
    checks += 1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_norow got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    bit exp_ack;
    bit exp_valid;
    for (int c = 0; c < 600; c++) begin
      bus.init          = ($urandom_range(7) == 0);
      bus.enable        = $urandom_range(1);
      bus.done          = ($urandom_range(5) == 0);
      bus.relu_en       = $urandom_range(1);
      bus.out_ready     = ($urandom_range(3) != 0);
      bus.bias          = DATA_W'($urandom);
      bus.adder_outputs = rand_tile();
      #1;
      exp_ack   = bus.done && (m_q.size() == 0);
      exp_valid = (m_q.size() != 0);
      checks += 4;
      if (bus.done_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, bus.done_ack, exp_ack); end
      if (bus.out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_valid); end
      if (bus.drain_busy !== exp_valid) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.drain_busy, exp_valid); end
      if (bus.buffer_outputs !== model_active()) begin
        failures++; $display("FAIL rnd_buf c=%0d got=%h exp=%h", c, bus.buffer_outputs, model_active());
      end
      if (exp_valid) begin
        checks += 3;
        if (bus.out_row !== m_q[0]) begin failures++; $display("FAIL rnd_row c=%0d got=%h exp=%h", c, bus.out_row, m_q[0]); end
        if (bus.out_row_idx !== ROW_IDX_W'(HEIGHT - m_q.size())) begin
          failures++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, bus.out_row_idx, HEIGHT - m_q.size());
        end
        if (bus.out_last !== (m_q.size() == 1)) begin failures++; $display("FAIL rnd_last c=%0d got=%b", c, bus.out_last); end
      end
      tick();
    end
  endtask

  initial begin
    m_act = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_init();
    test_drain();
    test_relu();
    test_backpressure();
    test_init_priority();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
